// File: rtl/row_prefetch_buffer.sv
// Ping-pong line buffer: prefetches the next row pair from framebuffer RAM into the back bank
// while the scanner reads the front bank; banks swap on the row latch.
module row_prefetch_buffer #(
  parameter int COL_WIDTH   = 6,
  parameter int ROW_WIDTH   = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int RAM_LATENCY = 1
) (
  input  logic                           clk_in,
  input  logic                           reset,
  input  logic                           prefetch_start,
  input  logic [ROW_WIDTH-1:0]           prefetch_row,
  input  logic                           swap,
  input  logic [COL_WIDTH-1:0]           column_address,
  input  logic [DATA_WIDTH-1:0]          ram_data_in,
  output logic [ROW_WIDTH+COL_WIDTH:0]   ram_address,
  output logic                           ram_clk_enable,
  output logic [DATA_WIDTH-1:0]          rgb565_top,
  output logic [DATA_WIDTH-1:0]          rgb565_bottom,
  output logic                           busy,
  output logic                           back_ready,
  output logic [ROW_WIDTH-1:0]           front_row,
  output logic                           underrun
);

  localparam int IDX_WIDTH = COL_WIDTH + 1;
  localparam int DEPTH     = 2 ** COL_WIDTH;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                 state;
  logic [IDX_WIDTH-1:0]   req_idx;
  logic [IDX_WIDTH-1:0]   next_idx;
  logic [ROW_WIDTH-1:0]   fetch_row;
  logic                   front_bank;

  logic [RAM_LATENCY-1:0] cap_valid;
  logic [IDX_WIDTH-1:0]   cap_idx [RAM_LATENCY];
  logic                   cap_en;
  logic                   cap_half;
  logic [COL_WIDTH-1:0]   cap_col;
  logic                   cap_last;

  logic [DATA_WIDTH-1:0]  top_mem    [2*DEPTH];
  logic [DATA_WIDTH-1:0]  bottom_mem [2*DEPTH];

  assign next_idx = req_idx + 1'b1;
  assign cap_en   = cap_valid[RAM_LATENCY-1];
  assign cap_half = cap_idx[RAM_LATENCY-1][0];
  assign cap_col  = cap_idx[RAM_LATENCY-1][IDX_WIDTH-1:1];
  assign cap_last = cap_en && (cap_idx[RAM_LATENCY-1] == LAST_IDX);

  // Request index and valid follow the RAM through its read latency so data lands in the right slot
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cap_valid <= '0;
      for (int k = 0; k < RAM_LATENCY; k++) cap_idx[k] <= '0;
    end else begin
      cap_valid[0] <= ram_clk_enable;
      cap_idx[0]   <= req_idx;
      for (int k = 1; k < RAM_LATENCY; k++) begin
        cap_valid[k] <= cap_valid[k-1];
        cap_idx[k]   <= cap_idx[k-1];
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      req_idx        <= '0;
      fetch_row      <= '0;
      ram_address    <= '0;
      ram_clk_enable <= 1'b0;
      busy           <= 1'b0;
      back_ready     <= 1'b0;
      front_bank     <= 1'b0;
      front_row      <= '0;
      underrun       <= 1'b0;
    end else begin
      underrun <= 1'b0;
      // Swap is honoured only for a finished fetch; back_ready is low for the whole fetch
      if (swap) begin
        if (back_ready) begin
          front_bank <= ~front_bank;
          front_row  <= fetch_row;
          back_ready <= 1'b0;
        end else begin
          underrun <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (prefetch_start) begin
            state          <= READ;
            fetch_row      <= prefetch_row;
            req_idx        <= '0;
            ram_address    <= {1'b0, prefetch_row, {COL_WIDTH{1'b0}}};
            ram_clk_enable <= 1'b1;
            busy           <= 1'b1;
            back_ready     <= 1'b0;
          end
        end
        READ: begin
          // Top and bottom of each column are interleaved: half is the index LSB
          if (req_idx == LAST_IDX) begin
            ram_clk_enable <= 1'b0;
            state          <= DRAIN;
          end else begin
            req_idx     <= next_idx;
            ram_address <= {next_idx[0], fetch_row, next_idx[IDX_WIDTH-1:1]};
          end
        end
        DRAIN: begin
          if (cap_last) begin
            state      <= IDLE;
            busy       <= 1'b0;
            back_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (cap_en) begin
      if (cap_half) bottom_mem[{~front_bank, cap_col}] <= ram_data_in;
      else          top_mem[{~front_bank, cap_col}]    <= ram_data_in;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      rgb565_top    <= '0;
      rgb565_bottom <= '0;
    end else begin
      rgb565_top    <= top_mem[{front_bank, column_address}];
      rgb565_bottom <= bottom_mem[{front_bank, column_address}];
    end
  end

endmodule

// File: tb/tb_row_prefetch_buffer.sv
// Bench for row_prefetch_buffer: runs a latency-1 and a latency-3 instance side by side on shared
// control inputs, with word=address RAM models and a scoreboard of expected RAM requests.
module tb_row_prefetch_buffer;

  logic        clk_in;
  logic        reset;
  logic        prefetch_start;
  logic [3:0]  prefetch_row;
  logic        swap;
  logic [5:0]  column_address;

  logic [15:0] ram_data1, ram_data3;
  logic [10:0] ram_address1, ram_address3;
  logic        ram_ce1, ram_ce3;
  logic [15:0] top1, bot1, top3, bot3;
  logic        busy1, busy3, br1, br3, underrun1, underrun3;
  logic [3:0]  front_row1, front_row3;

  int checks = 0;
  int errors = 0;
  int req_count1 = 0;
  int req_count3 = 0;
  logic [10:0] q1 [$];
  logic [10:0] q3 [$];

  typedef struct {
    logic [5:0]  col;
    logic [15:0] top;
    logic [15:0] bottom;
  } read_vec_t;
  read_vec_t vecs [5];

  row_prefetch_buffer #(.RAM_LATENCY(1)) dut (
    .clk_in(clk_in), .reset(reset), .prefetch_start(prefetch_start), .prefetch_row(prefetch_row),
    .swap(swap), .column_address(column_address), .ram_data_in(ram_data1),
    .ram_address(ram_address1), .ram_clk_enable(ram_ce1), .rgb565_top(top1), .rgb565_bottom(bot1),
    .busy(busy1), .back_ready(br1), .front_row(front_row1), .underrun(underrun1)
  );

  row_prefetch_buffer #(.RAM_LATENCY(3)) dut3 (
    .clk_in(clk_in), .reset(reset), .prefetch_start(prefetch_start), .prefetch_row(prefetch_row),
    .swap(swap), .column_address(column_address), .ram_data_in(ram_data3),
    .ram_address(ram_address3), .ram_clk_enable(ram_ce3), .rgb565_top(top3), .rgb565_bottom(bot3),
    .busy(busy3), .back_ready(br3), .front_row(front_row3), .underrun(underrun3)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // RAM models return the address as data; outside a valid read slot they return a poison word
  logic [10:0] pipe1 = '0;
  logic        v1 = 1'b0;
  logic [10:0] pipe3 [3] = '{default: '0};
  logic [2:0]  v3 = '0;
  always @(posedge clk_in) begin
    pipe1    <= ram_address1;
    v1       <= ram_ce1;
    pipe3[0] <= ram_address3;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
    v3       <= {v3[1:0], ram_ce3};
  end
  assign ram_data1 = v1    ? {5'b0, pipe1}    : 16'hDEAD;
  assign ram_data3 = v3[2] ? {5'b0, pipe3[2]} : 16'hDEAD;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Every issued request is popped against the scoreboard
  always @(negedge clk_in) begin
    if (ram_ce1) begin
      req_count1++;
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("[TB] FAIL req1_unexpected: got address %h with no request expected", ram_address1);
      end else if (ram_address1 !== q1[0]) begin
        errors++;
        $display("[TB] FAIL req1_addr: got %h expected %h", ram_address1, q1[0]);
        void'(q1.pop_front());
      end else begin
        void'(q1.pop_front());
      end
    end
    if (ram_ce3) begin
      req_count3++;
      checks++;
      if (q3.size() == 0) begin
        errors++;
        $display("[TB] FAIL req3_unexpected: got address %h with no request expected", ram_address3);
      end else if (ram_address3 !== q3[0]) begin
        errors++;
        $display("[TB] FAIL req3_addr: got %h expected %h", ram_address3, q3[0]);
        void'(q3.pop_front());
      end else begin
        void'(q3.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Call at a negedge (fetch cycle 0); returns at the negedge of fetch cycle 1
  task automatic startFetch(input logic [3:0] row);
    logic [6:0] idx;
    for (int i = 0; i < 128; i++) begin
      idx = 7'(i);
      q1.push_back({idx[0], row, idx[6:1]});
      q3.push_back({idx[0], row, idx[6:1]});
    end
    req_count1 = 0;
    req_count3 = 0;
    prefetch_start = 1'b1;
    prefetch_row   = row;
    tick(1);
    prefetch_start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [5:0] col);
    column_address = col;
    tick(1);
  endtask

  task automatic doSwap();
    swap = 1'b1;
    tick(1);
    swap = 1'b0;
  endtask

  task automatic checkFront(input string name, input logic [3:0] row, input logic [5:0] col);
    applyStimulus(col);
    checkOutput({name, "_top1"}, top1, {5'b0, 1'b0, row, col});
    checkOutput({name, "_bot1"}, bot1, {5'b0, 1'b1, row, col});
    checkOutput({name, "_top3"}, top3, {5'b0, 1'b0, row, col});
    checkOutput({name, "_bot3"}, bot3, {5'b0, 1'b1, row, col});
  endtask

  initial begin
    vecs[0] = '{col: 6'd0,  top: 16'h0140, bottom: 16'h0540};
    vecs[1] = '{col: 6'd1,  top: 16'h0141, bottom: 16'h0541};
    vecs[2] = '{col: 6'd31, top: 16'h015F, bottom: 16'h055F};
    vecs[3] = '{col: 6'd32, top: 16'h0160, bottom: 16'h0560};
    vecs[4] = '{col: 6'd63, top: 16'h017F, bottom: 16'h057F};

    prefetch_start = 1'b0;
    prefetch_row   = '0;
    swap           = 1'b0;
    column_address = '0;
    reset          = 1'b0;
    #2 reset = 1'b1;
    tick(2);
    checkOutput("rst_ce",        16'(ram_ce1), 16'h0);
    checkOutput("rst_addr",      16'(ram_address1), 16'h0);
    checkOutput("rst_busy",      16'(busy1), 16'h0);
    checkOutput("rst_ready",     16'(br1), 16'h0);
    checkOutput("rst_underrun",  16'(underrun1), 16'h0);
    checkOutput("rst_front_row", 16'(front_row1), 16'h0);
    checkOutput("rst_top",       top1, 16'h0);
    checkOutput("rst_bot",       bot1, 16'h0);
    reset = 1'b0;
    tick(2);

    $display("[TB] fetch row 5, both latencies");
    startFetch(4'd5);
    checkOutput("t1_busy_c1", 16'(busy1), 16'h1);
    checkOutput("t1_ce_c1",   16'(ram_ce1), 16'h1);
    tick(128);
    checkOutput("t1_ready_c129", 16'(br1), 16'h0);
    checkOutput("t1_busy_c129",  16'(busy1), 16'h1);
    tick(1);
    checkOutput("t1_ready_c130", 16'(br1), 16'h1);
    checkOutput("t1_busy_c130",  16'(busy1), 16'h0);
    checkOutput("t1_req_count",  16'(req_count1), 16'd128);
    tick(1);
    checkOutput("t1_l3_ready_c131", 16'(br3), 16'h0);
    checkOutput("t1_l3_busy_c131",  16'(busy3), 16'h1);
    tick(1);
    checkOutput("t1_l3_ready_c132", 16'(br3), 16'h1);
    checkOutput("t1_l3_busy_c132",  16'(busy3), 16'h0);
    checkOutput("t1_l3_req_count",  16'(req_count3), 16'd128);
    tick(3);

    $display("[TB] swap to row 5 and read back");
    column_address = 6'd3;
    doSwap();
    checkOutput("t2_underrun", 16'(underrun1), 16'h0);
    tick(1);
    checkOutput("t2_top",       top1, 16'h0143);
    checkOutput("t2_bot",       bot1, 16'h0543);
    checkOutput("t2_front_row", 16'(front_row1), 16'd5);
    checkOutput("t2_ready_clr", 16'(br1), 16'h0);
    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].col);
      checkOutput($sformatf("t2_vec%0d_top1", v), top1, vecs[v].top);
      checkOutput($sformatf("t2_vec%0d_bot1", v), bot1, vecs[v].bottom);
      checkOutput($sformatf("t2_vec%0d_top3", v), top3, vecs[v].top);
      checkOutput($sformatf("t2_vec%0d_bot3", v), bot3, vecs[v].bottom);
    end

    $display("[TB] swap while busy");
    column_address = 6'd3;
    startFetch(4'd9);
    tick(59);
    doSwap();
    checkOutput("t3_underrun1", 16'(underrun1), 16'h1);
    checkOutput("t3_underrun3", 16'(underrun3), 16'h1);
    checkOutput("t3_busy",      16'(busy1), 16'h1);
    tick(1);
    checkOutput("t3_underrun_end", 16'(underrun1), 16'h0);
    checkOutput("t3_front_row",    16'(front_row1), 16'd5);
    checkOutput("t3_top_kept",     top1, 16'h0143);
    tick(68);
    checkOutput("t3_ready_c130", 16'(br1), 16'h1);
    checkOutput("t3_req_count",  16'(req_count1), 16'd128);
    tick(2);
    checkOutput("t3_l3_ready_c132", 16'(br3), 16'h1);

    $display("[TB] restart while ready, then ignored start while busy");
    startFetch(4'd12);
    checkOutput("t4_ready_clr", 16'(br1), 16'h0);
    tick(39);
    prefetch_start = 1'b1;
    prefetch_row   = 4'd2;
    tick(1);
    prefetch_start = 1'b0;
    tick(89);
    checkOutput("t4_ready_c130", 16'(br1), 16'h1);
    checkOutput("t4_req_count",  16'(req_count1), 16'd128);
    checkOutput("t4_queue_left", 16'(q1.size()), 16'd0);
    tick(2);
    checkOutput("t4_l3_ready", 16'(br3), 16'h1);
    checkOutput("t4_l3_req_count", 16'(req_count3), 16'd128);
    doSwap();
    tick(1);
    checkOutput("t4_front_row", 16'(front_row1), 16'd12);
    checkFront("t4_row12", 4'd12, 6'd3);

    $display("[TB] row 15, then swap and start together");
    startFetch(4'd15);
    tick(129);
    checkOutput("t5_ready_c130", 16'(br1), 16'h1);
    tick(1);
    checkOutput("t5_l3_ready_c131", 16'(br3), 16'h0);
    checkOutput("t5_l3_busy_c131",  16'(busy3), 16'h1);
    tick(1);
    checkOutput("t5_l3_ready_c132", 16'(br3), 16'h1);
    checkOutput("t5_l3_busy_c132",  16'(busy3), 16'h0);
    swap = 1'b1;
    startFetch(4'd7);
    swap = 1'b0;
    checkOutput("t5_swap_busy", 16'(busy1), 16'h1);
    tick(1);
    checkOutput("t5_front_row1", 16'(front_row1), 16'd15);
    checkOutput("t5_front_row3", 16'(front_row3), 16'd15);
    checkOutput("t5_no_underrun", 16'(underrun1), 16'h0);
    for (int c = 0; c < 64; c++) checkFront("t5_row15", 4'd15, 6'(c));
    tick(63);
    doSwap();
    checkOutput("t5_last_cap_underrun1", 16'(underrun1), 16'h1);
    checkOutput("t5_last_cap_ready1",    16'(br1), 16'h1);
    checkOutput("t5_last_cap_front1",    16'(front_row1), 16'd15);
    checkOutput("t5_l3_underrun",        16'(underrun3), 16'h1);
    tick(2);
    checkOutput("t5_l3_ready_row7", 16'(br3), 16'h1);
    doSwap();
    tick(1);
    checkOutput("t5_front_row7", 16'(front_row1), 16'd7);
    checkFront("t5_row7", 4'd7, 6'd3);
    checkFront("t5_row7", 4'd7, 6'd63);

    $display("[TB] reset mid-fetch");
    column_address = 6'd3;
    startFetch(4'd3);
    tick(69);
    reset = 1'b1;
    #1;
    checkOutput("t6_ce",        16'(ram_ce1), 16'h0);
    checkOutput("t6_ce3",       16'(ram_ce3), 16'h0);
    checkOutput("t6_busy",      16'(busy1), 16'h0);
    checkOutput("t6_ready",     16'(br1), 16'h0);
    checkOutput("t6_top",       top1, 16'h0);
    checkOutput("t6_bot",       bot1, 16'h0);
    checkOutput("t6_front_row", 16'(front_row1), 16'h0);
    q1.delete();
    q3.delete();
    tick(3);
    checkOutput("t6_ce_held", 16'(ram_ce1), 16'h0);
    reset = 1'b0;
    tick(2);
    startFetch(4'd6);
    tick(129);
    checkOutput("t6_ready_c130", 16'(br1), 16'h1);
    checkOutput("t6_req_count",  16'(req_count1), 16'd128);
    tick(2);
    checkOutput("t6_l3_ready", 16'(br3), 16'h1);
    doSwap();
    tick(1);
    checkOutput("t6_front_row6", 16'(front_row1), 16'd6);
    checkFront("t6_row6", 4'd6, 6'd3);
    checkFront("t6_row6", 4'd6, 6'd63);
    checkFront("t6_row6", 4'd6, 6'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
